// File: rtl/raster_pkg.sv
// raster_pkg: shared widths, constants and the sequencer state type for the
// angle animation path (angle_sequencer and its button debouncers).
package raster_pkg;

    localparam int unsigned ANGLE_W   = 9;    // angle bus width, values 0..359
    localparam int unsigned ANGLE_MOD = 360;  // degrees per revolution
    localparam int unsigned SPEED_W   = 2;    // sw_speed width, step = 1 << sw_speed
    localparam int unsigned MATH_W    = 10;   // headroom for angle + step before the wrap

    typedef enum logic [1:0] {
        StRun,
        StPause,
        StStep
    } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a stability counter for one raw
// board button.
//   clk_pix   in   pixel clock
//   rst       in   synchronous active-high reset (button treated as released)
//   btn_raw   in   asynchronous raw button level
//   btn_level out  debounced level
//   btn_rise  out  one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_pix,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        // Any cycle where the synchronised input agrees with the accepted level
        // restarts the count, so only an uninterrupted run is accepted.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;

endmodule

// File: rtl/angle_sequencer.sv
// angle_sequencer: per-frame rotation angle controller. The angle advances once
// per frame on the vsync assert edge, so it is stable across the active frame.
//   clk_pix   in   pixel clock
//   rst       in   synchronous active-high reset
//   vsync     in   raw vsync (polarity set by VSYNC_ACTIVE_LOW)
//   btn_pause in   raw button, toggles run/pause
//   btn_step  in   raw button, single-frame advance while paused
//   btn_dir   in   raw button, toggles rotation direction
//   sw_speed  in   step per frame = 1 << sw_speed degrees
//   angle     out  current angle 0..359
//   paused    out  high in PAUSE or STEP
//   dir_rev   out  high when rotating backwards
// Build option: define ANGLE_PINGPONG_EN to bounce off 359/0 instead of wrapping.
module angle_sequencer
    import raster_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 250000,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk_pix,
    input  logic               rst,
    input  logic               vsync,
    input  logic               btn_pause,
    input  logic               btn_step,
    input  logic               btn_dir,
    input  logic [SPEED_W-1:0] sw_speed,
    output logic [ANGLE_W-1:0] angle,
    output logic               paused,
    output logic               dir_rev
);

    logic               ev_pause, ev_step, ev_dir;
    logic [2:0]         btn_levels;
    logic               unused_btn_level;

    logic               vs_act, vs_q, vs_d, tick;
    seq_state_e         state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               dir_q, dir_d;
    logic               advance;

    logic [MATH_W-1:0]  step_s, angle_ext, sum, nxt;
    logic               bounce, bounce_dir;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk_pix  (clk_pix),
        .rst      (rst),
        .btn_raw  (btn_pause),
        .btn_level(btn_levels[0]),
        .btn_rise (ev_pause)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk_pix  (clk_pix),
        .rst      (rst),
        .btn_raw  (btn_step),
        .btn_level(btn_levels[1]),
        .btn_rise (ev_step)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
        .clk_pix  (clk_pix),
        .rst      (rst),
        .btn_raw  (btn_dir),
        .btn_level(btn_levels[2]),
        .btn_rise (ev_dir)
    );

    // Only the edge events are used here.
    assign unused_btn_level = ^btn_levels;

    // Vsync assert-edge detection. vs_q resets to "asserted" so releasing reset in
    // the middle of vsync does not produce a tick.
    assign vs_act = vsync ^ VSYNC_ACTIVE_LOW;
    assign vs_d   = vs_act;
    assign tick   = vs_act & ~vs_q;

    // State register
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q <= StRun;
            vs_q    <= 1'b1;
            angle_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_d;
            angle_q <= angle_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic; pause has priority over step.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (ev_pause) state_d = StPause;
            end
            StPause: begin
                if (ev_pause)     state_d = StRun;
                else if (ev_step) state_d = StStep;
            end
            StStep: begin
                if (ev_pause)  state_d = StRun;
                else if (tick) state_d = StPause;
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs. The advance decision looks at the current state, so an event
    // landing on the tick cycle only affects later frames.
    always_comb begin
        advance = tick & ((state_q == StRun) | (state_q == StStep));
        paused  = (state_q != StRun);
    end

    // Angle datapath, 10-bit unsigned. Uses the current direction, so a
    // coincident ev_dir applies from the next frame.
    always_comb begin
        step_s     = MATH_W'(1) << sw_speed;
        angle_ext  = MATH_W'(angle_q);
        sum        = angle_ext + step_s;
        nxt        = angle_ext;
        bounce     = 1'b0;
        bounce_dir = dir_q;
        if (!dir_q) begin
            if (sum >= MATH_W'(ANGLE_MOD)) begin
`ifdef ANGLE_PINGPONG_EN
                // Reflect off 359: 359 - (sum - 359).
                nxt        = MATH_W'(2 * (ANGLE_MOD - 1)) - sum;
                bounce     = 1'b1;
                bounce_dir = 1'b1;
`else
                nxt = sum - MATH_W'(ANGLE_MOD);
`endif
            end else begin
                nxt = sum;
            end
        end else begin
            if (angle_ext < step_s) begin
`ifdef ANGLE_PINGPONG_EN
                // Reflect off 0.
                nxt        = step_s - angle_ext;
                bounce     = 1'b1;
                bounce_dir = 1'b0;
`else
                nxt = angle_ext + MATH_W'(ANGLE_MOD) - step_s;
`endif
            end else begin
                nxt = angle_ext - step_s;
            end
        end

        angle_d = advance ? nxt[ANGLE_W-1:0] : angle_q;
        // A button press flips whatever direction the frame update settles on.
        dir_d   = ((advance & bounce) ? bounce_dir : dir_q) ^ ev_dir;
    end

    assign angle   = angle_q;
    assign dir_rev = dir_q;

endmodule

// File: tb/tb_angle_sequencer.sv
// tb_angle_sequencer: directed self-checking bench for angle_sequencer with
// DEBOUNCE_CYCLES=4 and active-low vsync. Expected values are hand computed;
// a few differ when ANGLE_PINGPONG_EN is defined.
module tb_angle_sequencer;

`ifdef ANGLE_PINGPONG_EN
    localparam int EXP_REV8 = 4;    // 4 reverse by 8 bounces to 4, dir forward
    localparam int EXP_D_A  = 0;
    localparam int EXP_FWD4 = 8;
    localparam int EXP_D_B  = 1;
`else
    localparam int EXP_REV8 = 356;  // 4 reverse by 8 wraps to 356
    localparam int EXP_D_A  = 1;
    localparam int EXP_FWD4 = 352;
    localparam int EXP_D_B  = 0;
`endif

    logic       clk_pix = 1'b0;
    logic       rst;
    logic       vsync;
    logic       btn_pause, btn_step, btn_dir;
    logic [1:0] sw_speed;
    logic [8:0] angle;
    logic       paused;
    logic       dir_rev;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_pix = ~clk_pix;

    angle_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_pix  (clk_pix),
        .rst      (rst),
        .vsync    (vsync),
        .btn_pause(btn_pause),
        .btn_step (btn_step),
        .btn_dir  (btn_dir),
        .sw_speed (sw_speed),
        .angle    (angle),
        .paused   (paused),
        .dir_rev  (dir_rev)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_pix);
    endtask

    // Drop vsync, check the angle holds until the next edge and has moved right after it.
    task automatic do_tick(input string tag, input int exp_before, input int exp_after);
        @(negedge clk_pix);
        vsync = 1'b0;
        check_eq({tag, "_pre"}, 32'(angle), 32'(exp_before));
        @(posedge clk_pix);
        #1;
        check_eq(tag, 32'(angle), 32'(exp_after));
        wait_cycles(3);
        vsync = 1'b1;
        wait_cycles(3);
    endtask

    // mask = {dir, step, pause}; held for 'hold' cycles then released and allowed to settle.
    task automatic press(input logic [2:0] mask, input int hold);
        @(negedge clk_pix);
        btn_pause = mask[0];
        btn_step  = mask[1];
        btn_dir   = mask[2];
        wait_cycles(hold);
        btn_pause = 1'b0;
        btn_step  = 1'b0;
        btn_dir   = 1'b0;
        wait_cycles(8);
    endtask

    initial begin
        rst       = 1'b1;
        vsync     = 1'b1;
        btn_pause = 1'b0;
        btn_step  = 1'b0;
        btn_dir   = 1'b0;
        sw_speed  = 2'd0;
        wait_cycles(3);
        check_eq("rst_angle", 32'(angle), 0);
        check_eq("rst_paused", 32'(paused), 0);
        check_eq("rst_dir", 32'(dir_rev), 0);
        rst = 1'b0;
        wait_cycles(3);

        // Basic advance, s = 1
        do_tick("t1_a", 0, 1);
        do_tick("t1_b", 1, 2);
        do_tick("t1_c", 2, 3);
        do_tick("t1_d", 3, 4);

        // Reverse by 8 from 4, then reverse by 4, then forward by 8 across 360
        press(3'b100, 10);
        check_eq("dir_on", 32'(dir_rev), 1);
        sw_speed = 2'd3;
        do_tick("rev8", 4, EXP_REV8);
        check_eq("rev8_dir", 32'(dir_rev), EXP_D_A);
        sw_speed = 2'd2;
        do_tick("step4", EXP_REV8, EXP_FWD4);
        press(3'b100, 10);
        check_eq("dir_flip", 32'(dir_rev), EXP_D_B);
        sw_speed = 2'd3;
        do_tick("wrap8", EXP_FWD4, 0);
        check_eq("wrap8_dir", 32'(dir_rev), EXP_D_B);

        // Pause, frozen ticks, single step
        sw_speed = 2'd0;
        press(3'b001, 10);
        check_eq("paused_on", 32'(paused), 1);
        do_tick("pause_a", 0, 0);
        do_tick("pause_b", 0, 0);
        press(3'b010, 10);
        check_eq("step_paused", 32'(paused), 1);
        do_tick("step_adv", 0, 1);
        check_eq("step_paused2", 32'(paused), 1);
        check_eq("step_dir", 32'(dir_rev), 0);
        do_tick("step_once", 1, 1);

        // Pause and step together: pause wins
        press(3'b011, 10);
        check_eq("both_run", 32'(paused), 0);
        do_tick("run_again", 1, 2);
        sw_speed = 2'd3;
        do_tick("to_ten", 2, 10);

        // Bouncy direction button: only the stable press counts
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pix);
            btn_dir = 1'b1;
            wait_cycles(3);
            btn_dir = 1'b0;
            wait_cycles(2);
        end
        wait_cycles(6);
        check_eq("bounce_none", 32'(dir_rev), 0);
        press(3'b100, 10);
        check_eq("bounce_one", 32'(dir_rev), 1);
        sw_speed = 2'd1;
        do_tick("rev2", 10, 8);

        // Reset asserted and released while vsync is low
        @(negedge clk_pix);
        rst   = 1'b1;
        vsync = 1'b0;
        @(posedge clk_pix);
        #1;
        check_eq("mid_rst_angle", 32'(angle), 0);
        check_eq("mid_rst_dir", 32'(dir_rev), 0);
        check_eq("mid_rst_paused", 32'(paused), 0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(4);
        check_eq("no_spurious", 32'(angle), 0);
        vsync = 1'b1;
        wait_cycles(3);
        do_tick("after_rst", 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
